// File: rtl/crosshair_color_sampler.sv
// rtl/crosshair_color_sampler.sv - 4x4 crosshair window colour averager/classifier; optional SAMPLER_DROP_CNT_EN adds dropped_cnt
module crosshair_color_sampler #(
    parameter logic [9:0]  R_THRESH    = 10'd512,
    parameter logic [11:0] LUMA_THRESH = 12'd1536
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [9:0] VGA_R_In,
    input  logic [9:0] VGA_G_In,
    input  logic [9:0] VGA_B_In,
    input  logic [9:0] VGA_X,
    input  logic [9:0] VGA_Y,
    input  logic       pixel_valid,
    input  logic       run,
    input  logic       sample_ready,
    output logic       sample_valid,
    output logic [3:0] data,
    output logic [9:0] avg_R,
    output logic [9:0] avg_G,
    output logic [9:0] avg_B
`ifdef SAMPLER_DROP_CNT_EN
    ,
    output logic [7:0] dropped_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        CLASSIFY = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [13:0] sum_r, sum_g, sum_b;
    logic [4:0]  count;
    logic        clr, add, load;

    // Pixel qualifiers: frame origin, crosshair window, and the window's final pixel
    logic frame_start, in_win, win_last, transfer;
    assign frame_start = pixel_valid && (VGA_X == 10'd0) && (VGA_Y == 10'd0);
    assign in_win      = pixel_valid && (VGA_X >= 10'd462) && (VGA_X <= 10'd465)
                                     && (VGA_Y >= 10'd272) && (VGA_Y <= 10'd275);
    assign win_last    = in_win && (VGA_X == 10'd465) && (VGA_Y == 10'd275);
    assign transfer    = (state == HOLD) && sample_valid && sample_ready;

    // Averages are the sums divided by 16; luma is summed at 12 bits so it cannot wrap
    logic [9:0]  cur_r, cur_g, cur_b;
    logic [11:0] luma;
    assign cur_r = sum_r[13:4];
    assign cur_g = sum_g[13:4];
    assign cur_b = sum_b[13:4];
    assign luma  = {2'b00, cur_r} + {2'b00, cur_g} + {2'b00, cur_b};

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_n;
    end

    // Next state and datapath controls; run aborts any sample not yet presented
    always_comb begin
        state_n = state;
        clr     = 1'b0;
        add     = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                clr = 1'b1;
                if (frame_start && !run) state_n = ACCUM;
            end
            ACCUM: begin
                if (run) begin
                    clr     = 1'b1;
                    state_n = IDLE;
                end else if (in_win) begin
                    add = 1'b1;
                    if (count == 5'd15) state_n = CLASSIFY;
                end else if (frame_start) begin
                    clr = 1'b1;
                end
            end
            CLASSIFY: begin
                if (run) begin
                    clr     = 1'b1;
                    state_n = IDLE;
                end else begin
                    load    = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (transfer) begin
                    clr     = 1'b1;
                    state_n = run ? IDLE : ACCUM;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Accumulators, registered outputs and the valid/ready handshake
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sum_r        <= '0;
            sum_g        <= '0;
            sum_b        <= '0;
            count        <= '0;
            sample_valid <= 1'b0;
            data         <= '0;
            avg_R        <= '0;
            avg_G        <= '0;
            avg_B        <= '0;
        end else begin
            if (clr) begin
                sum_r <= '0;
                sum_g <= '0;
                sum_b <= '0;
                count <= '0;
            end else if (add) begin
                sum_r <= sum_r + {4'b0000, VGA_R_In};
                sum_g <= sum_g + {4'b0000, VGA_G_In};
                sum_b <= sum_b + {4'b0000, VGA_B_In};
                count <= count + 5'd1;
            end
            if (load) begin
                avg_R        <= cur_r;
                avg_G        <= cur_g;
                avg_B        <= cur_b;
                data         <= {cur_r >= R_THRESH, cur_g >= R_THRESH,
                                 cur_b >= R_THRESH, luma >= LUMA_THRESH};
                sample_valid <= 1'b1;
            end else if (transfer) begin
                sample_valid <= 1'b0;
            end
        end
    end

`ifdef SAMPLER_DROP_CNT_EN
    // A frame is lost when its window finishes while a sample is still held,
    // or when a partially collected window is thrown away at frame start
    logic drop;
    assign drop = ((state == ACCUM) && !run && !in_win && frame_start && (count != 5'd0))
               || ((state == HOLD) && win_last);

    // Saturating lost-frame counter
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                         dropped_cnt <= '0;
        else if (drop && dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_crosshair_color_sampler.sv
// tb/tb_crosshair_color_sampler.sv - scoreboard bench for crosshair_color_sampler
module tb_crosshair_color_sampler;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [9:0] VGA_R_In, VGA_G_In, VGA_B_In, VGA_X, VGA_Y;
    logic       pixel_valid, run, sample_ready;
    logic       sample_valid;
    logic [3:0] data;
    logic [9:0] avg_R, avg_G, avg_B;
`ifdef SAMPLER_DROP_CNT_EN
    logic [7:0] dropped_cnt;
`endif

    crosshair_color_sampler dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .VGA_R_In     (VGA_R_In),
        .VGA_G_In     (VGA_G_In),
        .VGA_B_In     (VGA_B_In),
        .VGA_X        (VGA_X),
        .VGA_Y        (VGA_Y),
        .pixel_valid  (pixel_valid),
        .run          (run),
        .sample_ready (sample_ready),
        .sample_valid (sample_valid),
        .data         (data),
        .avg_R        (avg_R),
        .avg_G        (avg_G),
        .avg_B        (avg_B)
`ifdef SAMPLER_DROP_CNT_EN
        ,
        .dropped_cnt  (dropped_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] d;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [3:0] d, input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        exp_t e;
        e.d = d; e.r = r; e.g = g; e.b = b;
        q.push_back(e);
    endtask

    // Monitor: every cycle a sample is presented it must match the queue head; pop on transfer
    always @(negedge CLK) begin
        if (RESET_N && sample_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_sample", 32'(sample_valid), 32'd0);
            end else begin
                chk("data",  32'(data),  32'(q[0].d));
                chk("avg_R", 32'(avg_R), 32'(q[0].r));
                chk("avg_G", 32'(avg_G), 32'(q[0].g));
                chk("avg_B", 32'(avg_B), 32'(q[0].b));
                if (sample_ready) void'(q.pop_front());
            end
        end
    end

    task automatic pix(input logic [9:0] x, input logic [9:0] y,
                       input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        VGA_X = x; VGA_Y = y; VGA_R_In = r; VGA_G_In = g; VGA_B_In = b;
        pixel_valid = 1'b1;
        @(posedge CLK); #1;
        pixel_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        pixel_valid = 1'b0;
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    // One abbreviated frame: origin, a stray pixel, then rows 272..275 over X 461..466
    task automatic frame(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                         input bit ramp, input bit chk_lat, input int abort_after);
        int idx = 0;
        pix(10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
        pix(10'd10, 10'd5, 10'h3FF, 10'h3FF, 10'h3FF);
        for (int y = 272; y <= 275; y++) begin
            for (int x = 461; x <= 466; x++) begin
                if (x >= 462 && x <= 465) begin
                    pix(10'(x), 10'(y), ramp ? r + 10'(idx) : r, g, b);
                    idx++;
                    if (abort_after != 0 && idx == abort_after) run = 1'b1;
                end else begin
                    pix(10'(x), 10'(y), 10'h3FF, 10'h3FF, 10'h3FF);
                end
                if (chk_lat && y == 275 && x == 465) chk("lat_pre",   32'(sample_valid), 32'd0);
                if (chk_lat && y == 275 && x == 466) chk("lat_valid", 32'(sample_valid), 32'd1);
            end
        end
        idle(1);
        if (chk_lat) chk("lat_drop", 32'(sample_valid), 32'd0);
        idle(3);
    endtask

    initial begin
        RESET_N = 1'b0; run = 1'b0; sample_ready = 1'b0; pixel_valid = 1'b0;
        VGA_X = '0; VGA_Y = '0; VGA_R_In = '0; VGA_G_In = '0; VGA_B_In = '0;
        #2;
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_data",  32'(data),  32'd0);
        chk("rst_avg_R", 32'(avg_R), 32'd0);
        chk("rst_avg_G", 32'(avg_G), 32'd0);
        chk("rst_avg_B", 32'(avg_B), 32'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        idle(2);

        sample_ready = 1'b1;
        push_exp(4'b1111, 10'd800, 10'd800, 10'd800);
        frame(10'd800, 10'd800, 10'd800, 1'b0, 1'b1, 0);

        push_exp(4'b1000, 10'd1023, 10'd0, 10'd0);
        frame(10'd1023, 10'd0, 10'd0, 1'b0, 1'b1, 0);

        push_exp(4'b0000, 10'd507, 10'd0, 10'd0);
        frame(10'd500, 10'd0, 10'd0, 1'b1, 1'b0, 0);

        push_exp(4'b0000, 10'd511, 10'd511, 10'd511);
        frame(10'd511, 10'd511, 10'd511, 1'b0, 1'b0, 0);

        push_exp(4'b1111, 10'd512, 10'd512, 10'd512);
        frame(10'd512, 10'd512, 10'd512, 1'b0, 1'b0, 0);

        push_exp(4'b0110, 10'd100, 10'd600, 10'd600);
        frame(10'd100, 10'd600, 10'd600, 1'b0, 1'b0, 0);

        // Backpressure: one sample held across three dropped frames
        sample_ready = 1'b0;
        push_exp(4'b0111, 10'd300, 10'd700, 10'd900);
        frame(10'd300, 10'd700, 10'd900, 1'b0, 1'b0, 0);
        frame(10'd10, 10'd10, 10'd10, 1'b0, 1'b0, 0);
        frame(10'd20, 10'd20, 10'd20, 1'b0, 1'b0, 0);
        frame(10'd30, 10'd30, 10'd30, 1'b0, 1'b0, 0);
`ifdef SAMPLER_DROP_CNT_EN
        chk("dropped_cnt", 32'(dropped_cnt), 32'd3);
`endif
        chk("held_valid", 32'(sample_valid), 32'd1);
        sample_ready = 1'b1;
        idle(3);
        chk("held_released", 32'(sample_valid), 32'd0);
        push_exp(4'b1111, 10'd800, 10'd800, 10'd800);
        frame(10'd800, 10'd800, 10'd800, 1'b0, 1'b0, 0);

        // run abort after 8 window pixels, then a normal frame
        frame(10'd900, 10'd900, 10'd900, 1'b0, 1'b0, 8);
        run = 1'b0;
        idle(2);
        push_exp(4'b1000, 10'd1023, 10'd0, 10'd0);
        frame(10'd1023, 10'd0, 10'd0, 1'b0, 1'b0, 0);

        // Reset while holding a sample
        sample_ready = 1'b0;
        push_exp(4'b0110, 10'd100, 10'd600, 10'd600);
        frame(10'd100, 10'd600, 10'd600, 1'b0, 1'b0, 0);
        chk("pre_rst_valid", 32'(sample_valid), 32'd1);
        RESET_N = 1'b0;
        #1;
        q.delete();
        chk("arst_valid", 32'(sample_valid), 32'd0);
        chk("arst_data",  32'(data),  32'd0);
        chk("arst_avg_R", 32'(avg_R), 32'd0);
        chk("arst_avg_G", 32'(avg_G), 32'd0);
        chk("arst_avg_B", 32'(avg_B), 32'd0);
        idle(2);
        RESET_N = 1'b1;
        sample_ready = 1'b1;
        idle(2);
        push_exp(4'b1111, 10'd512, 10'd512, 10'd512);
        frame(10'd512, 10'd512, 10'd512, 1'b0, 1'b1, 0);

        idle(5);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
